// File: rtl/ddr3_port_arbiter.sv
// Two-port round-robin arbiter in front of a DDR3 controller port.
// Single-word or block transfers, with a per-transaction idle timeout.
module ddr3_port_arbiter #(
    parameter int unsigned BW_ADDR        = 27,
    parameter int unsigned BLOCK_WORDS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               req0_i,
    input  logic               req1_i,
    input  logic               reqBlock0_i,
    input  logic               reqBlock1_i,
    input  logic               rw0_i,
    input  logic               rw1_i,
    input  logic [BW_ADDR-1:0] add0_i,
    input  logic [BW_ADDR-1:0] add1_i,
    input  logic [31:0]        data0_i,
    input  logic [31:0]        data1_i,
    output logic               ready0_o,
    output logic               ready1_o,
    output logic               done0_o,
    output logic               done1_o,
    output logic               valid0_o,
    output logic               valid1_o,
    output logic [31:0]        data0_o,
    output logic [31:0]        data1_o,
    output logic               mem_req_o,
    output logic               mem_reqBlock_o,
    output logic               mem_rw_o,
    output logic [BW_ADDR-1:0] mem_add_o,
    output logic [31:0]        mem_data_o,
    output logic               mem_clear_o,
    input  logic               mem_ready_i,
    input  logic               mem_done_i,
    input  logic               mem_valid_i,
    input  logic [31:0]        mem_data_i,
    output logic [1:0]         grant_o,
    output logic               timeout_o
);

    localparam int unsigned CntW  = $clog2(BLOCK_WORDS + 1);
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StClear} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic               r_owner;
    logic               r_last;
    logic               r_block;
    logic               r_rw;
    logic               r_timeout;
    logic [BW_ADDR-1:0] r_add;
    logic [CntW-1:0]    r_cnt;
    logic [IdleW-1:0]   r_idle;

    logic               w_busy;
    logic               w_pulse;
    logic               w_last_word;
    logic               w_expired;
    logic               w_grant_go;
    logic               w_winner;
    logic [CntW-1:0]    w_cnt_inc;
    logic [CntW-1:0]    w_target;

    always_comb begin
        w_busy      = (r_state == StBusy);
        w_pulse     = w_busy & (r_rw ? mem_done_i : mem_valid_i);
        w_cnt_inc   = r_cnt + CntW'(1);
        w_target    = r_block ? CntW'(BLOCK_WORDS) : CntW'(1);
        w_last_word = w_pulse & (w_cnt_inc == w_target);
        w_expired   = w_busy & ~w_pulse & (r_idle == IdleW'(TIMEOUT_CYCLES - 1));
        w_grant_go  = (r_state == StIdle) & mem_ready_i & (req0_i | req1_i);
        // With both requesting, the port not granted last wins.
        w_winner    = (req0_i & req1_i) ? ~r_last : ~req0_i;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_grant_go) w_state_next = StBusy;
            StBusy:  if (w_last_word || w_expired) w_state_next = StClear;
            StClear: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state   <= StIdle;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_block   <= 1'b0;
            r_rw      <= 1'b0;
            r_add     <= '0;
            r_cnt     <= '0;
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_go) begin
                r_owner <= w_winner;
                r_last  <= w_winner;
                r_block <= w_winner ? reqBlock1_i : reqBlock0_i;
                r_rw    <= w_winner ? rw1_i : rw0_i;
                r_add   <= w_winner ? add1_i : add0_i;
                r_cnt   <= '0;
                r_idle  <= '0;
            end else if (w_pulse) begin
                r_cnt  <= w_cnt_inc;
                r_idle <= '0;
            end else if (w_busy) begin
                r_idle <= r_idle + IdleW'(1);
            end
            if (w_expired) r_timeout <= 1'b1;
        end
    end

    always_comb begin
        ready0_o       = (r_state == StIdle) & mem_ready_i;
        ready1_o       = (r_state == StIdle) & mem_ready_i;
        grant_o        = (r_state == StIdle) ? 2'b00 : {r_owner, ~r_owner};
        mem_req_o      = w_busy;
        mem_clear_o    = (r_state == StClear);
        mem_reqBlock_o = w_busy & r_block;
        mem_rw_o       = w_busy & r_rw;
        mem_add_o      = w_busy ? r_add : '0;
        mem_data_o     = w_busy ? (r_owner ? data1_i : data0_i) : 32'd0;
        // Status reaches only the owner, and only while the transaction is live.
        done0_o        = w_busy & ~r_owner & mem_done_i;
        done1_o        = w_busy & r_owner & mem_done_i;
        valid0_o       = w_busy & ~r_owner & mem_valid_i;
        valid1_o       = w_busy & r_owner & mem_valid_i;
        data0_o        = mem_data_i;
        data1_o        = mem_data_i;
        timeout_o      = r_timeout;
    end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Randomized bench for ddr3_port_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ddr3_port_arbiter;

    localparam int BWA = 27;
    localparam int BW  = 4;
    localparam int TO  = 20;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           req0_i = 0, req1_i = 0, reqBlock0_i = 0, reqBlock1_i = 0;
    logic           rw0_i = 0, rw1_i = 0;
    logic [BWA-1:0] add0_i = '0, add1_i = '0;
    logic [31:0]    data0_i = '0, data1_i = '0;
    logic           mem_ready_i = 1'b1, mem_done_i = 1'b0, mem_valid_i = 1'b0;
    logic [31:0]    mem_data_i = '0;
    logic           ready0_o, ready1_o, done0_o, done1_o, valid0_o, valid1_o;
    logic [31:0]    data0_o, data1_o, mem_data_o;
    logic           mem_req_o, mem_reqBlock_o, mem_rw_o, mem_clear_o, timeout_o;
    logic [BWA-1:0] mem_add_o;
    logic [1:0]     grant_o;

    int n_cmp = 0;
    int n_bad = 0;

    ddr3_port_arbiter #(.BW_ADDR(BWA), .BLOCK_WORDS(BW), .TIMEOUT_CYCLES(TO)) dut (
        .clock_i(clk), .reset_i(reset_i),
        .req0_i(req0_i), .req1_i(req1_i),
        .reqBlock0_i(reqBlock0_i), .reqBlock1_i(reqBlock1_i),
        .rw0_i(rw0_i), .rw1_i(rw1_i), .add0_i(add0_i), .add1_i(add1_i),
        .data0_i(data0_i), .data1_i(data1_i),
        .ready0_o(ready0_o), .ready1_o(ready1_o), .done0_o(done0_o), .done1_o(done1_o),
        .valid0_o(valid0_o), .valid1_o(valid1_o), .data0_o(data0_o), .data1_o(data1_o),
        .mem_req_o(mem_req_o), .mem_reqBlock_o(mem_reqBlock_o), .mem_rw_o(mem_rw_o),
        .mem_add_o(mem_add_o), .mem_data_o(mem_data_o), .mem_clear_o(mem_clear_o),
        .mem_ready_i(mem_ready_i), .mem_done_i(mem_done_i), .mem_valid_i(mem_valid_i),
        .mem_data_i(mem_data_i), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: owner (-1 = none), words still owed, idle count.
    bit             m_valid = 0;
    int             m_owner = -1;
    bit             m_clear = 0;
    int             m_left = 0;
    int             m_idle = 0;
    bit             m_last = 1;
    bit             m_to = 0;
    bit             m_blk = 0, m_rw = 0;
    logic [BWA-1:0] m_add = '0;

    always @(negedge clk) begin
        bit idle, busy, pulse;
        int w;
        idle = (m_owner < 0);
        busy = !idle && !m_clear;
        if (m_valid) begin
            chk("ready0", ready0_o, idle && mem_ready_i);
            chk("ready1", ready1_o, idle && mem_ready_i);
            chk("grant", grant_o, idle ? 0 : (1 << m_owner));
            chk("mem_req", mem_req_o, busy);
            chk("mem_clear", mem_clear_o, m_clear);
            chk("mem_reqBlock", mem_reqBlock_o, busy && m_blk);
            chk("mem_rw", mem_rw_o, busy && m_rw);
            chk("mem_add", mem_add_o, busy ? m_add : '0);
            chk("mem_data", mem_data_o, busy ? (m_owner == 1 ? data1_i : data0_i) : 0);
            chk("done0", done0_o, busy && m_owner == 0 && mem_done_i);
            chk("done1", done1_o, busy && m_owner == 1 && mem_done_i);
            chk("valid0", valid0_o, busy && m_owner == 0 && mem_valid_i);
            chk("valid1", valid1_o, busy && m_owner == 1 && mem_valid_i);
            chk("data0", data0_o, mem_data_i);
            chk("data1", data1_o, mem_data_i);
            chk("timeout", timeout_o, m_to);
        end
        if (reset_i) begin
            m_valid = 1; m_owner = -1; m_clear = 0; m_last = 1; m_to = 0; m_idle = 0;
        end else if (m_valid) begin
            if (idle) begin
                if (mem_ready_i && (req0_i || req1_i)) begin
                    w = (req0_i && req1_i) ? (m_last ? 0 : 1) : (req0_i ? 0 : 1);
                    m_owner = w;
                    m_last = (w == 1);
                    m_blk = w ? reqBlock1_i : reqBlock0_i;
                    m_rw = w ? rw1_i : rw0_i;
                    m_add = w ? add1_i : add0_i;
                    m_left = m_blk ? BW : 1;
                    m_idle = 0;
                end
            end else if (m_clear) begin
                m_owner = -1;
                m_clear = 0;
            end else begin
                pulse = m_rw ? mem_done_i : mem_valid_i;
                if (pulse) begin
                    m_left--;
                    m_idle = 0;
                    if (m_left == 0) m_clear = 1;
                end else begin
                    m_idle++;
                    if (m_idle >= TO) begin
                        m_clear = 1;
                        m_to = 1;
                    end
                end
            end
        end
    end

    task automatic quiet_inputs();
        req0_i = 0; req1_i = 0; reqBlock0_i = 0; reqBlock1_i = 0; rw0_i = 0; rw1_i = 0;
        mem_done_i = 0; mem_valid_i = 0; mem_ready_i = 1;
    endtask

    task automatic do_reset();
        tick();
        quiet_inputs();
        reset_i = 1;
        tick();
        tick();
        reset_i = 0;
    endtask

    logic [31:0] wq [4];
    logic [1:0]  gseq [4];
    logic [1:0]  gprev;
    int          ng;
    int          nbusy;
    bit          seen_clear;
    int          quiet;

    initial begin
        wq[0] = 32'h1111_0000; wq[1] = 32'h2222_0001;
        wq[2] = 32'h3333_0002; wq[3] = 32'h4444_0003;
        tick(); tick(); tick();
        reset_i = 0;

        @(negedge clk);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_mem_req", mem_req_o, 0);

        // Single read on port 0.
        tick();
        req0_i = 1; rw0_i = 0; reqBlock0_i = 0; add0_i = 27'h100;
        @(negedge clk); chk("r1_ready0", ready0_o, 1);
        tick();
        req0_i = 0; add0_i = '0;
        @(negedge clk);
        chk("r1_grant", grant_o, 2'b01);
        chk("r1_add", mem_add_o, 27'h100);
        tick();
        mem_valid_i = 1; mem_data_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("r1_valid0", valid0_o, 1);
        chk("r1_data0", data0_o, 32'hDEADBEEF);
        chk("r1_valid1", valid1_o, 0);
        tick();
        mem_valid_i = 0;
        @(negedge clk);
        chk("r1_clear", mem_clear_o, 1);
        chk("r1_req", mem_req_o, 0);
        tick();
        @(negedge clk);
        chk("r1_grant_end", grant_o, 2'b00);

        // Block write on port 1.
        do_reset();
        req1_i = 1; reqBlock1_i = 1; rw1_i = 1; add1_i = 27'h2000;
        tick();
        req1_i = 0;
        for (int k = 0; k < 4; k++) begin
            data1_i = wq[k]; mem_done_i = 1;
            @(negedge clk);
            chk("bw_data", mem_data_o, wq[k]);
            chk("bw_done1", done1_o, 1);
            tick();
        end
        mem_done_i = 0;
        @(negedge clk);
        chk("bw_clear", mem_clear_o, 1);

        // Alternating grants with both ports requesting.
        do_reset();
        req0_i = 1; req1_i = 1; mem_valid_i = 1;
        ng = 0; gprev = 2'b00;
        for (int k = 0; k < 4; k++) gseq[k] = 2'b00;
        repeat (40) begin
            @(negedge clk);
            if (grant_o != 2'b00 && gprev == 2'b00 && ng < 4) begin
                gseq[ng] = grant_o;
                ng++;
            end
            gprev = grant_o;
        end
        chk("rr_count", ng, 4);
        chk("rr_g0", gseq[0], 2'b01);
        chk("rr_g1", gseq[1], 2'b10);
        chk("rr_g2", gseq[2], 2'b01);
        chk("rr_g3", gseq[3], 2'b10);

        // Read that never completes.
        do_reset();
        req1_i = 1; rw1_i = 0;
        tick();
        req1_i = 0;
        nbusy = 0; seen_clear = 0;
        for (int k = 0; k < 4 * TO && !seen_clear; k++) begin
            @(negedge clk);
            if (mem_clear_o) seen_clear = 1;
            else if (mem_req_o) nbusy++;
            tick();
        end
        chk("to_clear_seen", seen_clear, 1);
        chk("to_busy_cycles", nbusy, TO);
        repeat (3) tick();
        @(negedge clk);
        chk("to_sticky", timeout_o, 1);

        // Reset in the middle of a block write.
        do_reset();
        req0_i = 1; reqBlock0_i = 1; rw0_i = 1;
        tick();
        req0_i = 0;
        repeat (2) begin
            mem_done_i = 1;
            tick();
        end
        mem_done_i = 0;
        reset_i = 1;
        tick();
        reset_i = 0;
        @(negedge clk);
        chk("ra_grant", grant_o, 2'b00);
        chk("ra_clear", mem_clear_o, 0);
        chk("ra_timeout", timeout_o, 0);
        req0_i = 1; req1_i = 1;
        tick();
        req0_i = 0; req1_i = 0;
        @(negedge clk);
        chk("ra_regrant", grant_o, 2'b01);

        // Randomized traffic.
        quiet = 0;
        for (int n = 0; n < 4000; n++) begin
            tick();
            reset_i     = ($urandom_range(0, 299) == 0);
            req0_i      = ($urandom_range(0, 2) != 0);
            req1_i      = ($urandom_range(0, 2) != 0);
            reqBlock0_i = $urandom_range(0, 1);
            reqBlock1_i = $urandom_range(0, 1);
            rw0_i       = $urandom_range(0, 1);
            rw1_i       = $urandom_range(0, 1);
            add0_i      = BWA'($urandom);
            add1_i      = BWA'($urandom);
            data0_i     = $urandom;
            data1_i     = $urandom;
            mem_data_i  = $urandom;
            mem_ready_i = ($urandom_range(0, 7) != 0);
            if (quiet == 0 && $urandom_range(0, 149) == 0) quiet = TO + 5;
            if (quiet > 0) begin
                quiet--;
                mem_done_i = 0;
                mem_valid_i = 0;
            end else begin
                mem_done_i  = ($urandom_range(0, 9) < 3);
                mem_valid_i = ($urandom_range(0, 9) < 3);
            end
        end
        tick();
        quiet_inputs();
        tick();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
